// File: rtl/sd_pattern_moore.sv
// sd_pattern_moore: Moore serial pattern detector with overlap mode,
// sample enable and optional saturating match counter (SD_MATCH_CNT_EN).
// Ports: clk, reset (sync, active-low), en, in, overlap, cnt_clr ->
//   out (registered match), match_cnt, cnt_sat.
module sd_pattern_moore #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;

  // Next detection state; match_d is the flag the next state will carry,
  // so out can be a flop rather than a comparator on the output.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (en) begin
      hist_d = {hist_q[PAT_LEN-2:0], in};
      if (match_q && !overlap) begin
        // completed match bits are consumed; only the new bit counts
        fill_d = FW'(1);
      end else if (fill_q == FULL) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + FW'(1);
      end
    end
    match_d = (fill_d == FULL) && (hist_d == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign out = match_q;

`ifdef SD_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Clear wins over increment; increment only on an enabled edge
  // that lands in a matching state, and never past all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (en && match_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
  assign cnt_sat        = 1'b0;
`endif

endmodule

// File: doc/sd_pattern_moore.md
# sd_pattern_moore

Parametrised Moore-type serial sequence detector: the next generation of the fixed `1001` detector. It generalises the pattern to any compile-time width and value, adds runtime overlap/non-overlap mode, a sample-enable, and an optional saturating match counter. It sits on a 1-bit serial input stream. Downstream logic consumes `out` as a registered-state match indication.

## Interface
- `PAT_LEN`, 4: pattern length in bits; legal range 2..32.
- `PATTERN`, 4'b1001: pattern value, `PAT_LEN` bits wide.
  - The MSB is the first bit received.
- `CNT_W`, 8: match-counter width; legal range 1..16.

Ports:
- `clk` input 1: single clock; everything is updated on the rising edge.
- `reset` input 1: synchronous reset, active-low.
- `en` input 1: sample enable; `in` is consumed only on edges where `en`=1.
- `in` input 1: serial data bit.
- `overlap` input 1: detection mode.
  - 1: overlapping matches.
  - 0: non-overlapping matches.
  - Sampled on every enabled edge.
- `cnt_clr` input 1: synchronous clear of the match counter.
- `out` output 1: match flag; a pure function of registered state (Moore).
- `match_cnt` output CNT_W: number of matches, saturating.
- `cnt_sat` output 1: high while `match_cnt` equals all-ones.

## Operation
- State registers:
  - `hist[PAT_LEN-1:0]`: last bits received.
  - `fill`: count of valid bits in `hist`, 0..PAT_LEN, width clog2(PAT_LEN+1).
  - the counter.
- Match flag: `out` = (`fill`==PAT_LEN) && (`hist`==PATTERN).
  - No combinational path from `in`, `en` or `overlap` to `out`.
- On an enabled edge:
  - `hist` <= {`hist`[PAT_LEN-2:0], `in`}.
  - If `out`=1 and `overlap`=0: `fill` <= 1. The bits of the completed match are discarded and only the new bit counts.
  - Otherwise: `fill` <= min(`fill`+1, PAT_LEN).
- With `en`=0: all state holds, so `out` keeps its value.
- Counter: `match_cnt` increments by 1 on each enabled edge whose next state has `out`=1.
  - Saturates at 2^CNT_W−1 and never wraps.
- `cnt_clr`=1 forces `match_cnt` to 0 and has priority over an increment on the same edge.
  - Detection state is unaffected.
- Reset (`reset`=0 at an edge) clears `hist`, `fill`, `match_cnt`.
  - It overrides `en` and `cnt_clr`.
  - A partial pattern in progress is discarded.

## Timing
- Reset values: `out`=0, `match_cnt`=0, `cnt_sat`=0.
- Latency: the last pattern bit is sampled at edge k, and `out`=1 from just after edge k until the next enabled edge.
- `match_cnt` updates at the same edge k.
- Back-to-back matches in overlap mode hold `out` high across consecutive cycles.
  - Example: pattern 1111 with stream 11111.
- Mode change mid-stream takes effect at the edge where `overlap` is sampled. There is no flush.
- The first possible match is at the PAT_LEN-th enabled edge after reset.

## Configuration
- `SD_MATCH_CNT_EN` defined: the counter, `cnt_clr` and `cnt_sat` logic are compiled in, as described above.
- Not defined: the counter is compiled out.
  - `match_cnt` is tied to 0 and `cnt_sat` is tied to 0.
  - `cnt_clr` is ignored.
  - Ports remain, so the instantiation is unchanged.
  - Detection behaviour is identical.

## Test plan
All scenarios use the default parameters and `SD_MATCH_CNT_EN` defined unless stated.
- Overlap: `overlap`=1, `en`=1, stream 1,0,0,1,0,0,1 → `out`=1 after edges 4 and 7, `match_cnt`=2.
- Non-overlap: `overlap`=0, same stream → `out`=1 after edge 4 only, `match_cnt`=1. Then 0,0,1 → second match after edge 10, `match_cnt`=2.
- Enable gating: stream 1,0,0 with `en`=1, then 3 cycles `en`=0 with `in` toggling, then 1 with `en`=1 → match after the final edge. `out` held at 0 during the gap, then held 1 while `en` drops after the match.
- Reset mid-pattern: feed 1,0,0, assert `reset`=0 for one edge, release, feed 1 → no match, `out`=0, `match_cnt`=0. Also check that every output is 0 at reset.
- Saturation/clear: `CNT_W`=2, pattern 1001 overlap, 5 matches → `match_cnt`=3, `cnt_sat`=1. Pulse `cnt_clr` on the edge of a 6th match → `match_cnt`=0.
- Parametrisation/config: `PAT_LEN`=6, `PATTERN`=6'b110110, stream 110110110 overlap → 2 matches. Rebuild without `SD_MATCH_CNT_EN` → same `out` sequence, `match_cnt`=0 throughout.
